// File: rtl/riscv_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_fetch_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_INST_W = 32;

   localparam logic [DEF_INST_W-1:0] NOP_INST         = 32'h0000_0013;
   localparam logic [DEF_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] pc;
      logic [DEF_INST_W-1:0] inst;
   } fetch_entry_t;

   // Width needed to hold a count from 0 up to and including depth.
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Memory request/response, redirect and decode-side signals of the fetch unit.
interface riscv_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned INST_W = 32,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = riscv_fetch_pkg::cnt_w(DEPTH)
);
   logic              imem_req_valid;
   logic              imem_req_ready;
   logic [ADDR_W-1:0] imem_req_addr;
   logic              imem_rsp_valid;
   logic [INST_W-1:0] imem_rsp_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              stall;
   logic              if_valid;
   logic [INST_W-1:0] if_inst;
   logic [ADDR_W-1:0] if_pc;
   logic [ADDR_W-1:0] if_pc_four;
   logic [CNT_W-1:0]  fifo_count;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_pc_four, fifo_count,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_pc_four, fifo_count,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
   );
endinterface

// File: rtl/riscv_fetch_unit_fifo.sv
// Prefetch FIFO with a registered head entry; flush empties it but keeps the last head.
module fetch_fifo
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned CNT_W   = cnt_w(DEPTH),
   parameter type         entry_t = fetch_entry_t
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  entry_t           push_data_i,
   output entry_t           head_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t            mem_q [DEPTH];
   entry_t            head_q, head_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d, remain_s;
   logic              pop_s;

   // Next pointers, occupancy and head; an entry pushed into an otherwise empty FIFO bypasses storage.
   always_comb begin
      pop_s    = pop_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      remain_s = count_q - CNT_W'(pop_s);
      count_d  = remain_s + CNT_W'(push_i);
      if (count_d == '0) begin
         head_d = head_q;
      end else if (remain_s == '0) begin
         head_d = push_data_i;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointer, count and head registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;
endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: credit-limited request issue, in-order response
// tagging with PCs, and flush/drop handling on taken-branch redirects.
module riscv_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INST_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int unsigned       CNT_W    = cnt_w(DEPTH)
) (
   input logic                clk,
   input logic                reset,
   riscv_fetch_unit_if.master bus
);
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_s;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d, drop_q, drop_d, count_s;
   logic [CNT_W:0]    credit_used_s;
   logic              req_valid_s, accept_s, push_s, pop_s;
   entry_t            push_data_s, head_s;

   // Credits use start-of-cycle counts only, so a pop frees its slot one cycle later.
   always_comb begin
      credit_used_s = {1'b0, outstanding_q} + {1'b0, count_s};
      req_valid_s   = reset && !bus.redirect_valid && (credit_used_s < (CNT_W+1)'(DEPTH));
      accept_s      = req_valid_s && bus.imem_req_ready;
      target_s      = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      pop_s         = (count_s != '0) && !bus.stall;
      push_data_s   = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};
   end

   // Next-state for PCs, in-flight count and drop count; redirect overrides everything.
   always_comb begin
      outstanding_d = outstanding_q + CNT_W'(accept_s) - CNT_W'(bus.imem_rsp_valid);
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      drop_d        = drop_q;
      push_s        = 1'b0;
      if (bus.redirect_valid) begin
         fetch_pc_d = target_s;
         rsp_pc_d   = target_s;
         drop_d     = outstanding_q - CNT_W'(bus.imem_rsp_valid);
      end else begin
         if (accept_s) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(3'd4);
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (bus.imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1'b1);
         end else if (bus.imem_rsp_valid) begin
            push_s   = 1'b1;
            rsp_pc_d = rsp_pc_q + ADDR_W'(3'd4);
         end else begin
            drop_d = drop_q;
         end
      end
   end

   // Fetch state registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         drop_q        <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W),
      .entry_t (entry_t)
   ) u_fifo (
      .clk_i       (clk),
      .rst_ni      (reset),
      .push_i      (push_s),
      .pop_i       (pop_s),
      .flush_i     (bus.redirect_valid),
      .push_data_i (push_data_s),
      .head_o      (head_s),
      .count_o     (count_s)
   );

   assign bus.imem_req_valid = req_valid_s;
   assign bus.imem_req_addr  = fetch_pc_q;
   assign bus.if_valid       = (count_s != '0);
   assign bus.if_inst        = head_s.inst;
   assign bus.if_pc          = head_s.pc;
   assign bus.if_pc_four     = head_s.pc + ADDR_W'(3'd4);
   assign bus.fifo_count     = count_s;
endmodule
